// File: rtl/branch_predict_ctrl.sv
// Branch direction predictor (2-bit saturating counter table) with a
// misprediction recovery sequencer that redirects fetch and flushes wrong-path stages.
module branch_predict_ctrl #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pc_plus4,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int ENTRIES = 1 << IDX_BITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECOVER = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;
    logic                flush_if_id_q, flush_if_id_d;
    logic                flush_id_ex_q, flush_id_ex_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispredict_cnt_q, mispredict_cnt_d;
    logic [1:0]          table_q [ENTRIES];
    logic [1:0]          table_d [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic                resolve, mispredict;
    logic [1:0]          ex_ctr;
    logic                unused_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

    // Outcomes arriving during recovery belong to wrong-path instructions.
    assign resolve    = ex_valid & ex_is_branch & (state_q == ST_IDLE);
    assign mispredict = resolve & (ex_taken ^ ex_pred_taken);
    assign ex_ctr     = table_q[ex_idx];

    // No bypass: an aliasing update in the same cycle is seen only next cycle.
    assign pred_taken = table_q[if_idx][1];

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        table_d          = table_q;

        if (resolve) begin
            if (ex_taken && ex_ctr != 2'b11) begin
                table_d[ex_idx] = ex_ctr + 2'd1;
            end else if (!ex_taken && ex_ctr != 2'b00) begin
                table_d[ex_idx] = ex_ctr - 2'd1;
            end
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
        end
        if (mispredict && mispredict_cnt_q != '1) begin
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d       = ST_RECOVER;
                    redirect_pc_d = ex_taken ? ex_target : ex_pc_plus4;
                end
            end
            ST_RECOVER: state_d = ST_DRAIN;
            ST_DRAIN:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Control outputs are registered images of the state being entered.
        redirect_d    = (state_d == ST_RECOVER);
        flush_id_ex_d = (state_d == ST_RECOVER);
        flush_if_id_d = (state_d == ST_RECOVER) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            flush_if_id_q    <= 1'b0;
            flush_id_ex_q    <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else begin
            state_q          <= state_d;
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_if_id_q    <= flush_if_id_d;
            flush_id_ex_q    <= flush_id_ex_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            table_q          <= table_d;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_if_id_q;
    assign flush_id_ex    = flush_id_ex_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_branch_predict_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pc_plus4;
    logic        redirect, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispredict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        p;
        logic        r;
        logic [31:0] rpc;
        logic        fi;
        logic        fe;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];

    branch_predict_ctrl #(.IDX_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .ex_pc_plus4(ex_pc_plus4), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".pred_taken"},     {31'd0, pred_taken},  {31'd0, e.p});
            chk({e.name, ".redirect"},       {31'd0, redirect},    {31'd0, e.r});
            chk({e.name, ".redirect_pc"},    redirect_pc,          e.rpc);
            chk({e.name, ".flush_if_id"},    {31'd0, flush_if_id}, {31'd0, e.fi});
            chk({e.name, ".flush_id_ex"},    {31'd0, flush_id_ex}, {31'd0, e.fe});
            chk({e.name, ".branch_cnt"},     {16'd0, branch_cnt},  {16'd0, e.bc});
            chk({e.name, ".mispredict_cnt"}, {16'd0, mispredict_cnt}, {16'd0, e.mc});
        end
    end

    // Drive one cycle of inputs and queue the outputs expected before the next edge.
    task automatic step(input string name, input logic [31:0] ipc,
                        input logic v, input logic br, input logic [31:0] epc,
                        input logic tk, input logic pt, input logic [31:0] tgt,
                        input logic p, input logic r, input logic [31:0] rpc,
                        input logic fi, input logic fe, input logic [15:0] bc,
                        input logic [15:0] mc);
        exp_t e;
        if_pc = ipc; ex_valid = v; ex_is_branch = br; ex_pc = epc;
        ex_taken = tk; ex_pred_taken = pt; ex_target = tgt; ex_pc_plus4 = epc + 32'd4;
        e.name = name; e.p = p; e.r = r; e.rpc = rpc; e.fi = fi; e.fe = fe;
        e.bc = bc; e.mc = mc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_pc = '0; ex_valid = 0; ex_is_branch = 0; ex_pc = '0;
        ex_taken = 0; ex_pred_taken = 0; ex_target = '0; ex_pc_plus4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //     name        if_pc  v br ex_pc  tk pt target   | p r rpc    fi fe bc mc
        step("reset",      32'h10, 0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0);
        step("mp_taken",   32'h10, 1, 1, 32'h10, 1, 0, 32'h40,  0, 0, 32'h0,   0, 0, 0, 0);
        step("recover1",   32'h10, 0, 0, 32'h0,  0, 0, 32'h0,   1, 1, 32'h40,  1, 1, 1, 1);
        step("drain1",     32'h10, 0, 0, 32'h0,  0, 0, 32'h0,   1, 0, 32'h40,  1, 0, 1, 1);
        step("ok_t1",      32'h10, 1, 1, 32'h10, 1, 1, 32'h40,  1, 0, 32'h40,  0, 0, 1, 1);
        step("ok_t2",      32'h10, 1, 1, 32'h10, 1, 1, 32'h40,  1, 0, 32'h40,  0, 0, 2, 1);
        step("ok_t3_sat",  32'h10, 1, 1, 32'h10, 1, 1, 32'h40,  1, 0, 32'h40,  0, 0, 3, 1);
        step("mp_ntaken",  32'h10, 1, 1, 32'h10, 0, 1, 32'h40,  1, 0, 32'h40,  0, 0, 4, 1);
        step("wp_recover", 32'h10, 1, 1, 32'h10, 1, 0, 32'h80,  1, 1, 32'h14,  1, 1, 5, 2);
        step("wp_drain",   32'h10, 1, 1, 32'h10, 0, 1, 32'h80,  1, 0, 32'h14,  1, 0, 5, 2);
        step("after_wp",   32'h10, 0, 0, 32'h0,  0, 0, 32'h0,   1, 0, 32'h14,  0, 0, 5, 2);
        step("alias_old",  32'h18, 1, 1, 32'h58, 1, 1, 32'h100, 0, 0, 32'h14,  0, 0, 5, 2);
        step("alias_new",  32'h18, 0, 0, 32'h0,  0, 0, 32'h0,   1, 0, 32'h14,  0, 0, 6, 2);
        step("mp_prerst",  32'h10, 1, 1, 32'h10, 1, 0, 32'h200, 1, 0, 32'h14,  0, 0, 6, 2);

        // Now in RECOVER; reset asynchronously between clock edges.
        if_pc = 32'h10; ex_valid = 0; ex_is_branch = 0;
        #1;
        chk("in_recover.redirect",    {31'd0, redirect}, 32'd1);
        chk("in_recover.redirect_pc", redirect_pc, 32'h200);
        chk("in_recover.mp_cnt",      {16'd0, mispredict_cnt}, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst.redirect",    {31'd0, redirect}, 32'd0);
        chk("async_rst.redirect_pc", redirect_pc, 32'd0);
        chk("async_rst.flush_if_id", {31'd0, flush_if_id}, 32'd0);
        chk("async_rst.flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
        chk("async_rst.branch_cnt",  {16'd0, branch_cnt}, 32'd0);
        chk("async_rst.mp_cnt",      {16'd0, mispredict_cnt}, 32'd0);
        chk("async_rst.pred_taken",  {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        step("post_rst",   32'h18, 0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0);
        step("ok_nt",      32'h10, 1, 1, 32'h10, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0);
        step("after_nt",   32'h10, 0, 0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Direction predictor and misprediction recovery sequencer for the pipelined RISC-V core.
- IF stage: a direct-mapped table of 2-bit saturating counters indexed by fetch PC gives a taken/not-taken prediction.
- EX stage: compares the resolved branch outcome from the branch condition unit against the prediction carried down the pipe and updates the table.
- On mismatch: runs a short FSM that redirects the PC and flushes the wrong-path pipeline registers. Keeps performance counters.

Parameters:
IDX_BITS, 4, table index width; table holds 2**IDX_BITS entries, index = pc[IDX_BITS+1:2]
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
if_pc  input  32  PC of instruction being fetched
pred_taken  output  1  combinational prediction for if_pc: MSB of indexed counter
ex_valid  input  1  EX stage holds a real (non-bubble, non-stalled) instruction
ex_is_branch  input  1  EX instruction is a conditional branch
ex_pc  input  32  PC of EX instruction
ex_taken  input  1  resolved branch outcome from branch condition unit
ex_pred_taken  input  1  prediction made for this instruction at IF, carried via pipeline registers
ex_target  input  32  branch target (PC + imm)
ex_pc_plus4  input  32  fall-through address
redirect  output  1  registered; PC mux selects redirect_pc this cycle
redirect_pc  output  32  registered; corrected fetch address
flush_if_id  output  1  registered; zero IF/ID register
flush_id_ex  output  1  registered; zero ID/EX register
branch_cnt  output  CNT_W  branches resolved
mispredict_cnt  output  CNT_W  mispredictions detected

Behaviour:
- Reset (async, any time incl. mid-recovery):
  - state=IDLE; redirect, flush_if_id, flush_id_ex=0; redirect_pc=0.
  - All table entries=2'b01 (weakly not-taken); both counters=0.
  - Takes effect immediately, no clock needed.
- resolve = ex_valid & ex_is_branch & (state==IDLE). Inputs are ignored in RECOVER/DRAIN because they are wrong-path.
- mispredict = resolve & (ex_taken != ex_pred_taken).
- Table update on clock edge when resolve=1, at index ex_pc[IDX_BITS+1:2]:
  - ex_taken=1: saturating increment, 11 stays 11.
  - ex_taken=0: saturating decrement, 00 stays 00.
  - No wrap.
- pred_taken is a combinational read; no bypass. If if_pc and ex_pc alias the same index in the same cycle, pred_taken reflects the pre-update value.
- Aliasing between PCs sharing an index is permitted; no tags.
- Counters:
  - branch_cnt += 1 on each resolve.
  - mispredict_cnt += 1 on each mispredict.
  - Both saturate at all-ones (no wrap).
- FSM states IDLE, RECOVER, DRAIN:
  - IDLE: outputs redirect/flush low. On mispredict at edge N, go to RECOVER and latch redirect_pc = ex_taken ? ex_target : ex_pc_plus4.
  - RECOVER (cycle after N): redirect=1, flush_if_id=1, flush_id_ex=1. Next state DRAIN unconditionally.
  - DRAIN: flush_if_id=1 only, which discards the instruction fetched while redirect was being applied. Next state IDLE.
  - Total recovery penalty: 2 cycles after detection; back-to-back mispredicts cannot occur during recovery.
  - redirect_pc holds its value until the next mispredict.
- Correct predictions cause no redirect/flush and no state change.
- ex_valid=0 (stall/bubble): no update, no count, no transition.

Test Plan:
- Reset then if_pc=0x00000010 -> pred_taken=0 (entry 4 = 01); branch_cnt=mispredict_cnt=0; all control outputs 0.
- Branch at ex_pc=0x10, ex_pred_taken=0, ex_taken=1, ex_target=0x40 -> next cycle redirect=1, redirect_pc=0x40, both flushes=1; following cycle only flush_if_id=1; then all 0. Entry 4 becomes 10 (pred_taken=1), mispredict_cnt=1, branch_cnt=1.
- Resolve same PC taken 3 more times with correct prediction -> entry saturates at 11; no redirect/flush; branch_cnt=4, mispredict_cnt=1. Then one not-taken (pred 1) -> redirect_pc=ex_pc_plus4=0x14, entry=10.
- Mispredict at edge N, then ex_valid=1, ex_is_branch=1 with mismatching outcome during RECOVER and DRAIN -> ignored: no counter increment, no table change, FSM returns to IDLE after DRAIN.
- if_pc=0x10 and ex_pc=0x50 (same index 4) resolving taken in same cycle -> pred_taken shows old value; next cycle shows updated value.
- Assert rst asynchronously while in RECOVER -> outputs drop to 0 before next clock edge; table back to 01; counters 0; FSM IDLE.
